pipe_seq_ctrl: RTL and testbench

Central pipeline sequencer for the five-stage RV32I core. It owns every stage-register enable and clear, so stall/flush policy lives in one place and is not spread through the top level. It arbitrates load-use stalls, taken-branch flushes and data-memory wait states, and adds a post-reset bubble flush and a debug halt/single-step mode. It sits beside the hazard, branch and forwarding units and drives the fetch, decode and execute/memory/writeback register banks of the core top.

---
 rtl/pipe_seq_ctrl_if.sv | 30 +++
 rtl/pipe_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipe_seq_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_seq_ctrl_if.sv
// Hazard/handshake bundle between the core datapath and the pipeline sequencer.
// The master side (core top or bench) drives hazards and debug requests; the slave side is the sequencer.
interface pipe_seq_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             hdu_stall;
  logic             next_pc_src;
  logic             dm_req;
  logic             dm_ready;
  logic             halt_req;
  logic             step_req;
  logic             pc_en;
  logic             fd_en;
  logic             fd_clr;
  logic             de_clr;
  logic             pipe_en;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output hdu_stall, next_pc_src, dm_req, dm_ready, halt_req, step_req,
    input  pc_en, fd_en, fd_clr, de_clr, pipe_en, halted, mem_err, stall_cnt
  );

  modport slave (
    input  hdu_stall, next_pc_src, dm_req, dm_ready, halt_req, step_req,
    output pc_en, fd_en, fd_clr, de_clr, pipe_en, halted, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// Central five-stage pipeline sequencer: owns every stage-register enable/clear and arbitrates
// load-use stalls, branch flushes, data-memory waits, post-reset bubbles and debug halt/step.
module pipe_seq_ctrl #(
  parameter int FLUSH_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_seq_ctrl_if.slave bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WT_W = $clog2(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FLUSH    = 3'd0,
    S_RUN      = 3'd1,
    S_MEM_WAIT = 3'd2,
    S_HALTED   = 3'd3,
    S_STEP     = 3'd4
  } state_t;

  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic fd_clr;
    logic de_clr;
    logic pipe_en;
  } ctl_t;

  state_t           r_state;
  state_t           r_ret;
  logic [FC_W-1:0]  r_flush_cnt;
  logic [WT_W-1:0]  r_wait_cnt;
  logic             r_step_q;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;

  state_t           w_state_next;
  state_t           w_ret_next;
  logic [FC_W-1:0]  w_flush_next;
  logic [WT_W-1:0]  w_wait_next;
  logic             w_set_err;
  logic             w_count_stall;
  logic             w_freeze;
  logic             w_step_edge;
  logic             w_timeout;
  ctl_t             w_ctl;

  // Base decision, priority: memory freeze > taken branch > load-use stall > advance.
  // A taken branch also kills a simultaneous load-use stall so the PC is never held.
  function automatic ctl_t base_decision(input logic freeze, input logic br, input logic hdu);
    ctl_t c;
    c = '0;
    if (freeze) begin
      c = '0;
    end else if (br) begin
      c.pc_en   = 1'b1;
      c.fd_en   = 1'b1;
      c.fd_clr  = 1'b1;
      c.de_clr  = 1'b1;
      c.pipe_en = 1'b1;
    end else if (hdu) begin
      c.de_clr  = 1'b1;
      c.pipe_en = 1'b1;
    end else begin
      c.pc_en   = 1'b1;
      c.fd_en   = 1'b1;
      c.pipe_en = 1'b1;
    end
    return c;
  endfunction

  assign w_freeze    = bus.dm_req & ~bus.dm_ready;
  assign w_step_edge = bus.step_req & ~r_step_q;
  assign w_timeout   = (r_wait_cnt == WT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    w_ctl        = '0;
    w_state_next = r_state;
    w_ret_next   = r_ret;
    w_flush_next = r_flush_cnt;
    w_wait_next  = r_wait_cnt;
    w_set_err    = 1'b0;
    case (r_state)
      S_FLUSH: begin
        w_ctl.fd_clr  = 1'b1;
        w_ctl.de_clr  = 1'b1;
        w_ctl.pipe_en = 1'b1;
        if (r_flush_cnt == '0) begin
          w_state_next = S_RUN;
        end else begin
          w_flush_next = r_flush_cnt - FC_W'(1);
        end
      end
      S_RUN: begin
        w_ctl = base_decision(w_freeze, bus.next_pc_src, bus.hdu_stall);
        if (w_freeze) begin
          w_state_next = S_MEM_WAIT;
          w_ret_next   = S_RUN;
          w_wait_next  = '0;
        end else if (bus.halt_req) begin
          w_state_next = S_HALTED;
        end
      end
      S_MEM_WAIT: begin
        w_wait_next = r_wait_cnt + WT_W'(1);
        // Release on ready, or force it after the timeout so a dead slave cannot hang the core.
        if (bus.dm_ready || w_timeout) begin
          w_ctl        = base_decision(1'b0, bus.next_pc_src, bus.hdu_stall);
          w_state_next = r_ret;
          w_set_err    = ~bus.dm_ready;
        end
      end
      S_HALTED: begin
        if (w_step_edge) begin
          w_state_next = S_STEP;
        end else if (!bus.halt_req) begin
          w_state_next = S_RUN;
        end
      end
      S_STEP: begin
        w_ctl = base_decision(w_freeze, bus.next_pc_src, bus.hdu_stall);
        if (w_freeze) begin
          w_state_next = S_MEM_WAIT;
          w_ret_next   = S_HALTED;
          w_wait_next  = '0;
        end else begin
          w_state_next = S_HALTED;
        end
      end
      default: begin
        w_state_next = S_FLUSH;
      end
    endcase
  end

  assign w_count_stall = ((r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_MEM_WAIT))
                         && !w_ctl.pc_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_FLUSH;
      r_ret       <= S_RUN;
      r_flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
      r_wait_cnt  <= '0;
      r_step_q    <= 1'b0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ret       <= w_ret_next;
      r_flush_cnt <= w_flush_next;
      r_wait_cnt  <= w_wait_next;
      r_step_q    <= bus.step_req;
      r_mem_err   <= r_mem_err | w_set_err;
      if (w_count_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_en     = w_ctl.pc_en;
  assign bus.fd_en     = w_ctl.fd_en;
  assign bus.fd_clr    = w_ctl.fd_clr;
  assign bus.de_clr    = w_ctl.de_clr;
  assign bus.pipe_en   = w_ctl.pipe_en;
  assign bus.halted    = (r_state == S_HALTED);
  assign bus.mem_err   = r_mem_err;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed bench for pipe_seq_ctrl: reset flush, stalls, branch flush, memory wait/timeout,
// debug halt/step and reset out of HALTED, with hand-computed expected enables and counters.
module tb_pipe_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;

  // Output vector order: {pc_en, fd_en, fd_clr, de_clr, pipe_en}
  localparam logic [4:0] O_FLUSH = 5'b00111;
  localparam logic [4:0] O_RUN   = 5'b11001;
  localparam logic [4:0] O_HDU   = 5'b00011;
  localparam logic [4:0] O_FRZ   = 5'b00000;

  always #5 clk = ~clk;

  pipe_seq_ctrl_if #(.CNT_W(32)) bus ();

  pipe_seq_ctrl #(
    .FLUSH_CYCLES(4),
    .MEM_TIMEOUT (16),
    .CNT_W       (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [31:0] outs();
    return {27'd0, bus.pc_en, bus.fd_en, bus.fd_clr, bus.de_clr, bus.pipe_en};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      $display("ok   %-16s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [4:0] exp);
    #2;
    chk(tag, outs(), {27'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    bus.hdu_stall   = 1'b0;
    bus.next_pc_src = 1'b0;
    bus.dm_req      = 1'b0;
    bus.dm_ready    = 1'b0;
    bus.halt_req    = 1'b0;
    bus.step_req    = 1'b0;

    // Reset: FLUSH outputs, cleared status
    tick(); tick(); tick();
    step_chk("rst_outs", O_FLUSH);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_stall", bus.stall_cnt, 32'd0);
    chk("rst_mem_err", 32'(bus.mem_err), 32'd0);

    // Release: four bubble cycles (inputs ignored), fetch on the fifth
    rst_n = 1'b1;
    chk("flush_1", outs(), {27'd0, O_FLUSH});
    for (int i = 2; i <= 4; i++) begin
      tick();
      bus.hdu_stall = (i == 3);
      step_chk("flush_n", O_FLUSH);
    end
    tick();
    bus.hdu_stall = 1'b0;
    step_chk("run_first", O_RUN);
    chk("run_stall0", bus.stall_cnt, 32'd0);

    // Load-use stall, one cycle
    tick();
    bus.hdu_stall = 1'b1;
    step_chk("hdu_stall", O_HDU);
    tick();
    bus.hdu_stall = 1'b0;
    step_chk("hdu_after", O_RUN);
    chk("hdu_stall_cnt", bus.stall_cnt, 32'd1);

    // Branch together with load-use: branch wins
    tick();
    bus.hdu_stall   = 1'b1;
    bus.next_pc_src = 1'b1;
    #2;
    chk("br_pc_en", 32'(bus.pc_en), 32'd1);
    chk("br_fd_clr", 32'(bus.fd_clr), 32'd1);
    chk("br_de_clr", 32'(bus.de_clr), 32'd1);
    chk("br_pipe_en", 32'(bus.pipe_en), 32'd1);
    tick();
    bus.hdu_stall   = 1'b0;
    bus.next_pc_src = 1'b0;
    step_chk("br_after", O_RUN);
    chk("br_stall_cnt", bus.stall_cnt, 32'd1);

    // Data memory not ready for 3 cycles, release in the ready cycle
    tick();
    bus.dm_req = 1'b1;
    step_chk("mw_freeze1", O_FRZ);
    tick();
    step_chk("mw_freeze2", O_FRZ);
    tick();
    step_chk("mw_freeze3", O_FRZ);
    tick();
    bus.dm_ready = 1'b1;
    step_chk("mw_release", O_RUN);
    tick();
    bus.dm_req   = 1'b0;
    bus.dm_ready = 1'b0;
    step_chk("mw_after", O_RUN);
    chk("mw_stall_cnt", bus.stall_cnt, 32'd4);
    chk("mw_mem_err", 32'(bus.mem_err), 32'd0);

    // Memory never ready: RUN freeze cycle, 15 frozen wait cycles, forced advance on the 16th
    tick();
    bus.dm_req = 1'b1;
    step_chk("to_enter", O_FRZ);
    for (int i = 0; i < 15; i++) begin
      tick();
      step_chk("to_wait", O_FRZ);
    end
    tick();
    step_chk("to_force", O_RUN);
    chk("to_err_early", 32'(bus.mem_err), 32'd0);
    tick();
    bus.dm_req = 1'b0;
    step_chk("to_after", O_RUN);
    chk("to_mem_err", 32'(bus.mem_err), 32'd1);
    chk("to_stall_cnt", bus.stall_cnt, 32'd20);

    // Halt: sampling cycle still advances, HALTED from the next edge
    tick();
    bus.halt_req = 1'b1;
    step_chk("halt_sample", O_RUN);
    chk("halt_not_yet", 32'(bus.halted), 32'd0);
    tick();
    step_chk("halted_outs", O_FRZ);
    chk("halted_flag", 32'(bus.halted), 32'd1);

    // Three step pulses give three single advance cycles
    for (int k = 0; k < 3; k++) begin
      tick();
      bus.step_req = 1'b1;
      step_chk("pre_step", O_FRZ);
      tick();
      bus.step_req = 1'b0;
      step_chk("step_adv", O_RUN);
      chk("step_halted", 32'(bus.halted), 32'd0);
      tick();
      step_chk("post_step", O_FRZ);
      chk("post_halted", 32'(bus.halted), 32'd1);
    end

    // Held step level: only one step
    tick();
    bus.step_req = 1'b1;
    step_chk("hold_pre", O_FRZ);
    tick();
    step_chk("hold_step", O_RUN);
    tick();
    step_chk("hold_no_step1", O_FRZ);
    tick();
    step_chk("hold_no_step2", O_FRZ);
    tick();
    bus.step_req = 1'b0;
    step_chk("hold_release", O_FRZ);
    chk("halt_stall_cnt", bus.stall_cnt, 32'd20);

    // Step into a memory wait: STEP -> MEM_WAIT -> release -> HALTED
    tick();
    bus.step_req = 1'b1;
    step_chk("sm_pre", O_FRZ);
    tick();
    bus.step_req = 1'b0;
    bus.dm_req   = 1'b1;
    step_chk("sm_step", O_FRZ);
    chk("sm_step_halted", 32'(bus.halted), 32'd0);
    tick();
    step_chk("sm_wait", O_FRZ);
    tick();
    bus.dm_ready = 1'b1;
    step_chk("sm_release", O_RUN);
    tick();
    bus.dm_req   = 1'b0;
    bus.dm_ready = 1'b0;
    step_chk("sm_back", O_FRZ);
    chk("sm_halted", 32'(bus.halted), 32'd1);
    chk("sm_stall_cnt", bus.stall_cnt, 32'd22);

    // Drop halt: RUN next edge
    tick();
    bus.halt_req = 1'b0;
    step_chk("unhalt_cycle", O_FRZ);
    tick();
    step_chk("resume", O_RUN);
    chk("resume_halted", 32'(bus.halted), 32'd0);

    // Reset while HALTED with a step pending: straight to FLUSH, status cleared
    tick();
    bus.halt_req = 1'b1;
    step_chk("rh_sample", O_RUN);
    tick();
    bus.step_req = 1'b1;
    rst_n        = 1'b0;
    step_chk("rh_halted", O_FRZ);
    tick();
    step_chk("rh_flush", O_FLUSH);
    chk("rh_halted_flag", 32'(bus.halted), 32'd0);
    chk("rh_mem_err", 32'(bus.mem_err), 32'd0);
    chk("rh_stall_cnt", bus.stall_cnt, 32'd0);
    tick();
    rst_n        = 1'b1;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    step_chk("rh_still_flush", O_FLUSH);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
